wash_water_arbiter: RTL and testbench

//  Shares one hot-water heater / fill line between NUM_WASHERS washer FSMs in the laundry controller.

---
 rtl/wash_arb_pkg.sv | 15 +
 rtl/wash_water_arbiter_rr_picker.sv | 31 +++
 rtl/wash_water_arbiter.sv | 141 ++++++++++++++
 tb/tb_wash_water_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_arb_pkg.sv
// Shared state encoding and default sizing for the wash water arbiter.
// The optional hold limit is enabled by defining WASH_ARB_TIMEOUT_EN.
package wash_arb_pkg;

    localparam int NUM_WASHERS_DEF    = 4;
    localparam int MAX_HOLD_DEF       = 64;
    localparam int RECOVER_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wash_water_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping modulo N.
// Purely combinational; the arbiter registers the result.
module rr_picker
    import wash_arb_pkg::*;
#(
    parameter int N     = NUM_WASHERS_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] j;

    // Scanning from the far end lets the nearest request after rr_ptr win.
    always_comb begin
        found = 1'b0;
        index = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDX_W'((int'(rr_ptr) + k) % N);
            if (req[j]) begin
                found = 1'b1;
                index = j;
            end
        end
    end

endmodule

// File: rtl/wash_water_arbiter.sv
// Grants the shared hot-water line to one washer at a time, round-robin, with a recovery gap.
// Define WASH_ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module wash_water_arbiter
    import wash_arb_pkg::*;
#(
    parameter int NUM_WASHERS    = NUM_WASHERS_DEF,
    parameter int MAX_HOLD       = MAX_HOLD_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           power,
    input  logic [NUM_WASHERS-1:0]         req,
    output logic [NUM_WASHERS-1:0]         grant,
    output logic [$clog2(NUM_WASHERS)-1:0] grant_id,
    output logic                           busy,
    output logic                           timeout_pulse
);

    localparam int IDX_W  = $clog2(NUM_WASHERS);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int REC_W  = $clog2(RECOVER_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [REC_W-1:0]  REC_MAX   = REC_W'(RECOVER_CYCLES);
    localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(RECOVER_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_WASHERS - 1);

    arb_state_e             state, state_nxt;
    logic [NUM_WASHERS-1:0] grant_nxt;
    logic [IDX_W-1:0]       id_nxt;
    logic [IDX_W-1:0]       rr_ptr, ptr_nxt;
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
    logic [REC_W-1:0]       rec_cnt, rec_nxt;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_index;
    logic                   release_now;

    rr_picker #(
        .N     (NUM_WASHERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_index)
    );

    assign busy        = (state == ST_GRANT);
    assign release_now = !power || !req[grant_id];

`ifdef WASH_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic tpulse_nxt;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        id_nxt    = grant_id;
        ptr_nxt   = rr_ptr;
        hold_nxt  = hold_cnt;
        rec_nxt   = rec_cnt;
`ifdef WASH_ARB_TIMEOUT_EN
        tpulse_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (power && pick_found) begin
                    state_nxt             = ST_GRANT;
                    grant_nxt             = '0;
                    grant_nxt[pick_index] = 1'b1;
                    id_nxt                = pick_index;
                    hold_nxt              = '0;
                    ptr_nxt               = (pick_index == IDX_LAST) ? '0 : pick_index + 1'b1;
                end
            end
            ST_GRANT: begin
                // A release in the same cycle as the hold limit is a normal release.
                if (release_now) begin
                    state_nxt = ST_RECOVER;
                    grant_nxt = '0;
                    rec_nxt   = '0;
                end
`ifdef WASH_ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    state_nxt  = ST_RECOVER;
                    grant_nxt  = '0;
                    rec_nxt    = '0;
                    tpulse_nxt = 1'b1;
                end
`endif
                else begin
                    hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt == REC_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rec_nxt = (rec_cnt == REC_MAX) ? rec_cnt : rec_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            rec_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            grant_id <= id_nxt;
            rr_ptr   <= ptr_nxt;
            hold_cnt <= hold_nxt;
            rec_cnt  <= rec_nxt;
        end
    end

`ifdef WASH_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= tpulse_nxt;
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wash_water_arbiter.sv
// Bench for wash_water_arbiter (N=4, MAX_HOLD=8, RECOVER_CYCLES=2) against a cycle model of grants and gaps.
// Expectations follow WASH_ARB_TIMEOUT_EN when it is defined for the build.
module tb_wash_water_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;
    localparam int RC = 2;
`ifdef WASH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         power;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which washer holds the line, how long, and how many idle cycles remain before sampling.
    int m_g    = -1;
    int m_ptr  = 0;
    int m_len  = 0;
    int m_gap  = 0;
    int m_last = 0;
    bit m_pulse = 1'b0;

    wash_water_arbiter #(
        .NUM_WASHERS    (N),
        .MAX_HOLD       (MH),
        .RECOVER_CYCLES (RC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power         (power),
        .req           (req),
        .grant         (grant),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] e;
        e = '0;
        if (m_g >= 0) e[m_g] = 1'b1;
        return e;
    endfunction

    task automatic model_step();
        bit done;
        int j;
        m_pulse = 1'b0;
        if (rst) begin
            m_g = -1; m_ptr = 0; m_len = 0; m_gap = 0; m_last = 0;
        end else if (m_g >= 0) begin
            if (!power || !req[m_g]) begin
                m_g = -1; m_gap = RC;
            end else if (TO_EN && m_len == MH) begin
                m_g = -1; m_gap = RC; m_pulse = 1'b1;
            end else begin
                m_len++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (power && req != '0) begin
            done = 1'b0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!done && req[j]) begin
                    done = 1'b1; m_g = j; m_len = 1; m_ptr = (j + 1) % N; m_last = j;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; power = 1'b1; req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: grant=%b busy=%b, required grant=0000 busy=0", grant, busy);
            end
            n_cmp++;
            if (grant_id !== 2'd0 || timeout_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_vals: grant_id=%0d pulse=%b, required 0 and 0", grant_id, timeout_pulse);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || busy !== 1'b1 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_first_grant: grant=%b busy=%b id=%0d, required 0001 1 0", grant, busy, grant_id);
        end
        req = 4'b0000;
        for (int c = 0; c < RC + 3; c++) tick();
        n_cmp++;
        if (grant !== exp_grant()) begin
            n_bad++;
            $display("FAIL reset_release: grant=%b required %b", grant, exp_grant());
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL single_grant c%0d: grant=%b id=%0d busy=%b, required 0100 2 1", c, grant, grant_id, busy);
            end
        end
        req = 4'b0000;
        for (int c = 0; c < RC + 2; c++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd2) begin
                n_bad++;
                $display("FAIL single_release c%0d: grant=%b busy=%b id=%0d, required 0000 0 2", c, grant, busy, grant_id);
            end
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5];
        int hi;
        logic [N-1:0] prev;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = 4'b0000; power = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111; hi = 0; prev = '0;
        for (int c = 0; c < 45; c++) begin
            tick();
            n_cmp++;
            if (grant !== exp_grant() || busy !== (m_g >= 0) || grant_id !== 2'(m_last)) begin
                n_bad++;
                $display("FAIL rr_cycle c%0d: grant=%b busy=%b id=%0d, required %b %b %0d",
                         c, grant, busy, grant_id, exp_grant(), (m_g >= 0), m_last);
            end
            if (grant != '0 && prev == '0) order.push_back(int'(grant_id));
            prev = grant;
            hi = (grant != '0) ? hi + 1 : 0;
            req = (hi == 3) ? ~grant : 4'b1111;
        end
        n_cmp++;
        if (order.size() < 5) begin
            n_bad++;
            $display("FAIL rr_count: grants seen=%0d, required at least 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (order[k] !== exp_order[k]) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d]: washer %0d, required %0d", k, order[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_power_drop();
        int guard;
        req = 4'b0000;
        for (int c = 0; c < RC + 2; c++) tick();
        req = 4'b0010; guard = 0;
        do begin tick(); guard++; end while (grant !== 4'b0010 && guard < 10);
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL pwr_setup: grant=%b, required 0010 within 10 cycles", grant);
        end
        power = 1'b0; req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0000 || busy !== 1'b0 || grant !== exp_grant()) begin
                n_bad++;
                $display("FAIL pwr_off c%0d: grant=%b busy=%b, required 0000 0", c, grant, busy);
            end
        end
        power = 1'b1;
        tick();
        n_cmp++;
        if (grant !== exp_grant()) begin
            n_bad++;
            $display("FAIL pwr_restore: grant=%b required %b", grant, exp_grant());
        end
    endtask

    task automatic test_timeout();
        int first_run;
        int pulses;
        bit fell;
        rst = 1'b1; req = 4'b0000; power = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0001;
        first_run = 0; pulses = 0; fell = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_cmp++;
            if (grant !== exp_grant() || timeout_pulse !== m_pulse || busy !== (m_g >= 0)) begin
                n_bad++;
                $display("FAIL to_cycle c%0d: grant=%b pulse=%b busy=%b, required %b %b %b",
                         c, grant, timeout_pulse, busy, exp_grant(), m_pulse, (m_g >= 0));
            end
            if (grant == 4'b0001 && !fell) first_run++;
            if (grant != 4'b0001 && first_run > 0) fell = 1'b1;
            if (timeout_pulse === 1'b1) pulses++;
        end
        n_cmp++;
        if (first_run !== (TO_EN ? MH : 30) || pulses !== (TO_EN ? 2 : 0)) begin
            n_bad++;
            $display("FAIL to_summary: first run=%0d pulses=%0d, required %0d %0d",
                     first_run, pulses, (TO_EN ? MH : 30), (TO_EN ? 2 : 0));
        end
    endtask

    task automatic test_release_on_timeout();
        rst = 1'b1; req = 4'b0000; power = 1'b1;
        tick();
        rst = 1'b0; req = 4'b0001;
        for (int c = 0; c < MH; c++) tick();
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL rel_to_setup: grant=%b on cycle %0d of grant, required 0001", grant, MH);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || timeout_pulse !== 1'b0 || m_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL rel_to_pulse: grant=%b pulse=%b, required 0000 0", grant, timeout_pulse);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) power = ~power;
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            tick();
            n_cmp++;
            if (grant !== exp_grant() || busy !== (m_g >= 0) || grant_id !== 2'(m_last) ||
                timeout_pulse !== m_pulse) begin
                n_bad++;
                $display("FAIL rand c%0d: grant=%b busy=%b id=%0d pulse=%b, required %b %b %0d %b",
                         c, grant, busy, grant_id, timeout_pulse, exp_grant(), (m_g >= 0), m_last, m_pulse);
            end
        end
        rst = 1'b0; power = 1'b1;
    endtask

    initial begin
        rst = 1'b1; power = 1'b1; req = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_power_drop();
        test_timeout();
        test_release_on_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
